ohc5_add_arbiter: RTL and testbench
===================================

OHC5_ADD_ARBITER -- requirements
Module: ohc5_add_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the adder; legal range 2..8.
REQ-002 Parameter IDW, default 2: requester-ID width; SHALL equal clog2(NREQ).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req_valid  input  NREQ  per-requester operand-pair valid.
REQ-006 req_a  input  5*NREQ  one-hot mod-5 operand A; requester i uses bits [5i+4:5i]; bit k set means residue k.
REQ-007 req_b  input  5*NREQ  one-hot mod-5 operand B, packed the same way as req_a.
REQ-008 req_ready  output  NREQ  grant; at most one bit set per cycle.
REQ-009 res_valid  output  1  result register holds a result.
REQ-010 res_sum  output  5  one-hot (A+B) mod 5.
REQ-011 res_id  output  IDW  index of the requester that produced res_sum.
REQ-012 res_err  output  1  result came from a malformed operand.
REQ-013 res_ready  input  1  downstream accepts the result.
REQ-014 err_cnt  output  8  saturating count of malformed transactions.

Function
REQ-015 A transfer on requester i SHALL occur when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-016 Output transfer SHALL occur when res_valid and res_ready are both high at a rising edge.
REQ-017 The block SHALL contain exactly one combinational one-hot mod-5 adder, muxed to the granted requester.
REQ-018 The result register SHALL have two states: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-019 Transitions SHALL be:
- EMPTY->FULL on a grant.
- FULL->EMPTY on an output transfer with no grant.
- FULL->FULL on an output transfer with a simultaneous grant, which reloads the register.
- Otherwise the state SHALL hold.
REQ-020 Grants SHALL be enabled only when the register is EMPTY, or FULL with res_ready=1; this sustains one transaction per cycle.
REQ-021 req_ready SHALL be combinational from req_valid, rr_ptr and the grant enable; no grant SHALL be issued to a requester whose req_valid is low.
REQ-022 Round-robin priority: search order SHALL be rr_ptr, rr_ptr+1, ... mod NREQ.
REQ-023 After a grant to requester g, rr_ptr SHALL become (g+1) mod NREQ; with no grant, rr_ptr SHALL hold.
REQ-024 Latency SHALL be 1 cycle: a grant at edge N presents res_sum, res_id and res_err from edge N onward (visible in cycle N+1).
REQ-025 res_sum, res_id and res_err SHALL stay stable while res_valid=1 and res_ready=0.
REQ-026 An operand is malformed if it has zero or more than one bit set; a malformed transfer SHALL load res_sum=5'b00000 and res_err=1.
REQ-027 A well-formed transfer SHALL load res_err=0 and the exact one-hot modular sum.
REQ-028 err_cnt SHALL increment once per malformed grant and saturate at 255.
REQ-029 A requester may drop req_valid without having been granted; no state SHALL change as a result.
REQ-030 With res_ready held low, the block SHALL grant exactly one request, then stall all requesters indefinitely with no loss or duplication.

Reset
REQ-031 While rst=1 at an edge, the block SHALL clear res_valid, res_sum (to 5'b00000), res_id, res_err, err_cnt and rr_ptr, and set req_ready=0.
REQ-032 Reset mid-operation SHALL discard any held result; no grant or output transfer SHALL occur in a cycle where rst=1.
REQ-033 The first cycle after rst falls SHALL allow normal grants, with requester 0 at highest priority.

Verification
REQ-034 Single requester:
- Stimulus: requester 1, a=5'b00100 (residue 2), b=5'b01000 (residue 3), res_ready=1.
- Response: next cycle res_valid=1, res_sum=5'b00001, res_id=1, res_err=0.
REQ-035 All four requesters valid continuously with res_ready=1:
- Grants SHALL follow 0,1,2,3,0,...
- One result per cycle; res_id sequence matches the grant order.
REQ-036 Backpressure:
- Stimulus: res_ready=0 for 5 cycles, requesters 0 and 2 valid; requester 0 operands a=5'b01000 (residue 3), b=5'b10000 (residue 4).
- Response: a single grant (to requester 0); res_sum=5'b00100 held stable.
- Then res_ready=1: requester 2 granted in the same cycle as the output transfer.
REQ-037 Malformed operand:
- Stimulus: a=5'b00011 granted.
- Response: res_err=1, res_sum=5'b00000, err_cnt increments to 1.
- After 300 malformed grants, err_cnt reads 255.
REQ-038 Reset while FULL:
- Stimulus: rst pulsed for 1 cycle.
- Response: res_valid=0, err_cnt=0; the next grant goes to requester 0 when all four requesters are valid.
REQ-039 Exhaustive arithmetic: all 25 well-formed (A,B) pairs, each checked against (A+B) mod 5.

Source files
------------

// File: rtl/ohc5_add_arbiter.sv
// ohc5_add_arbiter: round-robin arbiter that lets NREQ requesters share a
// single one-hot mod-5 adder. The result sits in a one-entry register
// (EMPTY/FULL) with valid/ready handshakes on both sides, and malformed
// operands are counted.
module ohc5_add_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    localparam int unsigned OHW  = 5,
    localparam int unsigned CNTW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [OHW*NREQ-1:0]   req_a,
    input  logic [OHW*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    output logic [OHW-1:0]        res_sum,
    output logic [IDW-1:0]        res_id,
    output logic                  res_err,
    input  logic                  res_ready,
    output logic [CNTW-1:0]       err_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [OHW-1:0]  res_sum_q, res_sum_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic            res_err_q, res_err_d;
    logic [CNTW-1:0] err_cnt_q, err_cnt_d;

    logic            grant_en_c;
    logic            gnt_any_c;
    logic [IDW-1:0]  gnt_idx_c;
    logic            out_xfer_c;
    logic [OHW-1:0]  op_a_c;
    logic [OHW-1:0]  op_b_c;
    logic [OHW-1:0]  sum_raw_c;
    logic            malformed_c;
    int unsigned     cand;

    logic [OHW-1:0]  a_arr [NREQ];
    logic [OHW-1:0]  b_arr [NREQ];

    // Unpack the flat operand buses into per-requester slots
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[OHW*g +: OHW];
        assign b_arr[g] = req_b[OHW*g +: OHW];
    end

    // Grants are allowed when the result slot is free or is draining this cycle
    assign grant_en_c = !rst && ((state_q == EMPTY) || res_ready);
    assign out_xfer_c = (state_q == FULL) && res_ready;

    // Round-robin search starting at rr_ptr; first valid requester wins
    always_comb begin
        gnt_any_c = 1'b0;
        gnt_idx_c = '0;
        cand      = 0;
        req_ready = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = (32'(rr_ptr_q) + off) % NREQ;
            if (grant_en_c && !gnt_any_c && req_valid[IDW'(cand)]) begin
                gnt_any_c = 1'b1;
                gnt_idx_c = IDW'(cand);
            end
        end
        if (gnt_any_c) begin
            req_ready[gnt_idx_c] = 1'b1;
        end
    end

    // Operand mux feeding the single shared adder
    assign op_a_c = a_arr[gnt_idx_c];
    assign op_b_c = b_arr[gnt_idx_c];

    // One-hot mod-5 adder: bit k of the sum is set when residues i and j with (i+j)%5==k meet
    always_comb begin
        sum_raw_c[0] = (op_a_c[0] & op_b_c[0]) | (op_a_c[1] & op_b_c[4]) |
                       (op_a_c[2] & op_b_c[3]) | (op_a_c[3] & op_b_c[2]) |
                       (op_a_c[4] & op_b_c[1]);
        sum_raw_c[1] = (op_a_c[0] & op_b_c[1]) | (op_a_c[1] & op_b_c[0]) |
                       (op_a_c[2] & op_b_c[4]) | (op_a_c[3] & op_b_c[3]) |
                       (op_a_c[4] & op_b_c[2]);
        sum_raw_c[2] = (op_a_c[0] & op_b_c[2]) | (op_a_c[1] & op_b_c[1]) |
                       (op_a_c[2] & op_b_c[0]) | (op_a_c[3] & op_b_c[4]) |
                       (op_a_c[4] & op_b_c[3]);
        sum_raw_c[3] = (op_a_c[0] & op_b_c[3]) | (op_a_c[1] & op_b_c[2]) |
                       (op_a_c[2] & op_b_c[1]) | (op_a_c[3] & op_b_c[0]) |
                       (op_a_c[4] & op_b_c[4]);
        sum_raw_c[4] = (op_a_c[0] & op_b_c[4]) | (op_a_c[1] & op_b_c[3]) |
                       (op_a_c[2] & op_b_c[2]) | (op_a_c[3] & op_b_c[1]) |
                       (op_a_c[4] & op_b_c[0]);
    end

    // An operand with zero or several bits set poisons the whole transaction
    assign malformed_c = !$onehot(op_a_c) || !$onehot(op_b_c);

    // Next-state: result slot FSM, result payload, round-robin pointer, error counter
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        res_sum_d = res_sum_q;
        res_id_d  = res_id_q;
        res_err_d = res_err_q;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            EMPTY: begin
                if (gnt_any_c) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_xfer_c && !gnt_any_c) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (gnt_any_c) begin
            res_id_d  = gnt_idx_c;
            res_err_d = malformed_c;
            res_sum_d = malformed_c ? '0 : sum_raw_c;
            rr_ptr_d  = (gnt_idx_c == IDW'(NREQ - 1)) ? '0 : gnt_idx_c + IDW'(1);
            if (malformed_c && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + CNTW'(1);
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            rr_ptr_q  <= '0;
            res_sum_q <= '0;
            res_id_q  <= '0;
            res_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            res_sum_q <= res_sum_d;
            res_id_q  <= res_id_d;
            res_err_q <= res_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;
    assign res_err   = res_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ohc5_add_arbiter.sv
// Bench for ohc5_add_arbiter: a residue-arithmetic model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ohc5_add_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [5*NREQ-1:0] req_a;
    logic [5*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic [4:0]        res_sum;
    logic [IDW-1:0]    res_id;
    logic              res_err;
    logic              res_ready;
    logic [7:0]        err_cnt;

    int checks = 0;
    int errors = 0;
    int gnt_log[$];

    ohc5_add_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .res_err   (res_err),
        .res_ready (res_ready),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference arithmetic: decode residues, add as integers, re-encode
    task automatic model_add(input logic [4:0] a, input logic [4:0] b,
                             output logic [4:0] sum, output bit err);
        int na, nb, ra, rb;
        na = 0; nb = 0; ra = 0; rb = 0;
        for (int k = 0; k < 5; k++) begin
            if (a[k]) begin na++; ra = k; end
            if (b[k]) begin nb++; rb = k; end
        end
        err = (na != 1) || (nb != 1);
        sum = err ? 5'b00000 : (5'b00001 << ((ra + rb) % 5));
    endtask

    // Model state
    bit         m_full;
    logic [4:0] m_sum;
    int         m_id;
    bit         m_err;
    int         m_cnt;
    int         m_ptr;

    // Per-cycle compare against the model, then advance the model on this cycle's inputs
    initial begin
        logic [NREQ-1:0] exp_rdy;
        logic [4:0]      s;
        bit              e;
        int              g;
        int              c;
        m_full = 0; m_sum = '0; m_id = 0; m_err = 0; m_cnt = 0; m_ptr = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_rdy = '0;
            g = -1;
            if (!rst && (!m_full || res_ready)) begin
                for (int k = 0; k < NREQ; k++) begin
                    c = (m_ptr + k) % NREQ;
                    if (g < 0 && req_valid[c]) g = c;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;

            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("res_valid", 32'(res_valid), 32'(m_full));
            chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
            if (m_full) begin
                chk("res_sum", 32'(res_sum), 32'(m_sum));
                chk("res_id", 32'(res_id), 32'(m_id));
                chk("res_err", 32'(res_err), 32'(m_err));
            end

            for (int k = 0; k < NREQ; k++) begin
                if (req_ready[k] && req_valid[k]) gnt_log.push_back(k);
            end

            if (rst) begin
                m_full = 0; m_sum = '0; m_id = 0; m_err = 0; m_cnt = 0; m_ptr = 0;
            end else if (g >= 0) begin
                model_add(req_a[g*5 +: 5], req_b[g*5 +: 5], s, e);
                m_full = 1;
                m_sum  = s;
                m_id   = g;
                m_err  = e;
                if (e && m_cnt < 255) m_cnt++;
                m_ptr  = (g + 1) % NREQ;
            end else if (m_full && res_ready) begin
                m_full = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int r, input logic [4:0] a, input logic [4:0] b);
        req_a[r*5 +: 5] = a;
        req_b[r*5 +: 5] = b;
    endtask

    // Directed scenarios
    initial begin
        int         base;
        logic [4:0] ea;
        logic [4:0] eb;
        logic [4:0] exp_sum;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_sum", 32'(res_sum), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;

        // Single requester: residue 2 + residue 3 = residue 0
        set_op(1, 5'b00100, 5'b01000);
        req_valid = 4'b0010;
        res_ready = 1'b1;
        cyc();
        chk("single_valid", 32'(res_valid), 32'd1);
        chk("single_sum", 32'(res_sum), 32'h01);
        chk("single_id", 32'(res_id), 32'd1);
        chk("single_err", 32'(res_err), 32'd0);
        req_valid = '0;
        cyc();
        chk("single_drain", 32'(res_valid), 32'd0);

        // Full load from fresh reset: grants rotate 0,1,2,3,0,...
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        set_op(0, 5'b00001, 5'b00010);
        set_op(1, 5'b00010, 5'b00010);
        set_op(2, 5'b10000, 5'b10000);
        set_op(3, 5'b01000, 5'b00100);
        req_valid = 4'b1111;
        gnt_log.delete();
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("rr_valid", 32'(res_valid), 32'd1);
            chk("rr_id", 32'(res_id), 32'(i % 4));
        end
        chk("rr_count", 32'(gnt_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) begin
            chk("rr_order", 32'(gnt_log[i]), 32'(i % 4));
        end
        req_valid = '0;
        cyc();

        // Backpressure: single grant to 0, held stable, then 2 granted on the drain cycle
        set_op(0, 5'b01000, 5'b10000);
        set_op(2, 5'b00001, 5'b00010);
        res_ready = 1'b0;
        req_valid = 4'b0101;
        gnt_log.delete();
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_sum", 32'(res_sum), 32'h04);
            chk("bp_id", 32'(res_id), 32'd0);
            req_valid = (i == 2) ? 4'b0001 : 4'b0101;
        end
        chk("bp_one_grant", 32'(gnt_log.size()), 32'd1);
        res_ready = 1'b1;
        cyc();
        chk("bp_regrant_id", 32'(res_id), 32'd2);
        chk("bp_regrant_sum", 32'(res_sum), 32'h02);
        chk("bp_grants", 32'(gnt_log.size()), 32'd2);
        if (gnt_log.size() == 2) chk("bp_second", 32'(gnt_log[1]), 32'd2);
        req_valid = '0;
        cyc();

        // Malformed operands: error flag, zero sum, saturating counter
        set_op(0, 5'b00011, 5'b00001);
        req_valid = 4'b0001;
        cyc();
        chk("mal_err", 32'(res_err), 32'd1);
        chk("mal_sum", 32'(res_sum), 32'd0);
        chk("mal_cnt1", 32'(err_cnt), 32'd1);
        for (int i = 1; i < 300; i++) begin
            if (i == 150) set_op(0, 5'b00100, 5'b00000);
            cyc();
        end
        chk("mal_cnt_sat", 32'(err_cnt), 32'd255);

        // Reset while FULL with all requesters asking
        set_op(0, 5'b00010, 5'b00100);
        set_op(1, 5'b00001, 5'b00001);
        set_op(2, 5'b00001, 5'b00001);
        set_op(3, 5'b00001, 5'b00001);
        req_valid = 4'b1111;
        rst = 1'b1;
        cyc();
        chk("rstf_valid", 32'(res_valid), 32'd0);
        chk("rstf_cnt", 32'(err_cnt), 32'd0);
        chk("rstf_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        cyc();
        chk("rstf_first_id", 32'(res_id), 32'd0);
        chk("rstf_first_sum", 32'(res_sum), 32'h08);
        req_valid = '0;
        cyc();

        // Every well-formed residue pair through requester 3
        req_valid = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                ea = 5'b00001 << i;
                eb = 5'b00001 << j;
                set_op(3, ea, eb);
                cyc();
                exp_sum = 5'b00001 << ((i + j) % 5);
                chk("exh_sum", 32'(res_sum), 32'(exp_sum));
                chk("exh_err", 32'(res_err), 32'd0);
                chk("exh_id", 32'(res_id), 32'd3);
            end
        end
        req_valid = '0;
        cyc();

        // Mixed traffic with random backpressure, checked by the model only
        for (int i = 0; i < 200; i++) begin
            for (int r = 0; r < NREQ; r++) begin
                base = int'($urandom_range(0, 4));
                ea = 5'b00001 << base;
                base = int'($urandom_range(0, 4));
                eb = 5'b00001 << base;
                if ($urandom_range(0, 9) == 0) ea = 5'($urandom);
                set_op(r, ea, eb);
            end
            req_valid = 4'($urandom);
            res_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        req_valid = '0;
        res_ready = 1'b1;
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
